// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encodings and cycle constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH      = 32;
  localparam int unsigned MDU_MUL_CYCLES = 4;
  localparam int unsigned MDU_DIV_CYCLES = MDU_WIDTH;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_muldiv(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_seq.sv
// Restoring divider, one quotient bit per step; quotient/remainder outputs reflect the
// result of the step taken this cycle, with sign fixup and divide-by-zero override applied.
module mdu_div_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             abort_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_c_o,
  output logic [WIDTH-1:0] rem_c_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_q;
  logic             negq_q, negr_q, zero_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial;
  logic             fits;

  assign a_neg = signed_i & dividend_i[WIDTH-1];
  assign b_neg = signed_i & divisor_i[WIDTH-1];
  assign a_mag = a_neg ? (~dividend_i + WIDTH'(1)) : dividend_i;
  assign b_mag = b_neg ? (~divisor_i + WIDTH'(1)) : divisor_i;

  // Shift next dividend bit into the partial remainder and try subtracting the divisor.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    fits  = ~trial[WIDTH];
    rem_d = fits ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_d = {quo_q[WIDTH-2:0], fits};
  end

  always_comb begin
    quot_c_o = negq_q ? (~quo_d + WIDTH'(1)) : quo_d;
    rem_c_o  = negr_q ? (~rem_d + WIDTH'(1)) : rem_d;
    if (zero_q) begin
      quot_c_o = '1;
      rem_c_o  = dvd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (abort_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= a_mag;
      dvs_q  <= b_mag;
      dvd_q  <= dividend_i;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
      zero_q <= (divisor_i == '0);
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MULT/DIV unit in EX: owns HI/LO and drives the E-stage ready handshake.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = MDU_WIDTH,
  parameter int unsigned MUL_CYCLES = MDU_MUL_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       MDUOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             GoHandlerM,
  output logic             MDUReadyE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE
);

  localparam int unsigned CYC_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  mdu_op_e          op_in;
  logic             ready_c;
  logic             div_start, div_step, div_abort;
  logic [WIDTH-1:0] div_quot, div_rem;
  logic             mul_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign op_in = mdu_op_e'(MDUOpE);

  // Low 2W bits of the product of sign/zero-extended operands give the exact result.
  assign mul_signed = (op_q == MDU_MULT);
  assign a_ext = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  mdu_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .step_i     (div_step),
    .abort_i    (div_abort),
    .signed_i   (op_in == MDU_DIV),
    .dividend_i (SrcAE),
    .divisor_i  (SrcBE),
    .quot_c_o   (div_quot),
    .rem_c_o    (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ready_c   = 1'b1;
    div_start = 1'b0;
    div_step  = 1'b0;
    div_abort = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_muldiv(op_in)) begin
          ready_c   = 1'b0;
          op_d      = op_in;
          a_d       = SrcAE;
          b_d       = SrcBE;
          div_start = is_div(op_in);
          count_d   = is_div(op_in) ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_CYCLES - 1);
          state_d   = ST_BUSY;
        end else if (op_in == MDU_MTHI) begin
          hi_d = SrcAE;
        end else if (op_in == MDU_MTLO) begin
          lo_d = SrcAE;
        end
      end
      ST_BUSY: begin
        ready_c  = 1'b0;
        div_step = is_div(op_q);
        count_d  = count_q - CNT_W'(1);
        if (count_q == '0) begin
          count_d = '0;
          state_d = ST_DONE;
          if (is_div(op_q)) begin
            hi_d = div_rem;
            lo_d = div_quot;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Exception flush squashes E: release the stall, drop any pending write or operation.
    if (GoHandlerM) begin
      ready_c   = 1'b1;
      state_d   = ST_IDLE;
      count_d   = '0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      div_start = 1'b0;
      div_step  = 1'b0;
      div_abort = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign MDUReadyE = ready_c;
  assign HiE       = hi_q;
  assign LoE       = lo_q;

endmodule
